// File: rtl/aes128_inv_cipher_iter_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES-128
// inverse cipher. The S-box and inverse S-box are built from the field inverse
// plus the affine maps rather than from a stored table.
package aes128_inv_cipher_iter_pkg;

    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Round constant used when stepping from round key rnd back to rnd-1.
    // Unreachable counter values decode to zero.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd10:   rc = 8'h36;
            4'd9:    rc = 8'h1b;
            4'd8:    rc = 8'h80;
            4'd7:    rc = 8'h40;
            4'd6:    rc = 8'h20;
            4'd5:    rc = 8'h10;
            4'd4:    rc = 8'h08;
            4'd3:    rc = 8'h04;
            4'd2:    rc = 8'h02;
            4'd1:    rc = 8'h01;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box affine transform.
    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse of the S-box affine transform.
    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes128_inv_cipher_iter_sbox.sv
// Byte substitution boxes: sbox is used by the key-schedule SubWord, inv_sbox by
// InvSubBytes on the state. Both are purely combinational.
module sbox
    import aes128_inv_cipher_iter_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] dout
);

    assign dout = aff_fwd(gf_inv(data));

endmodule

module inv_sbox
    import aes128_inv_cipher_iter_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] dout
);

    assign dout = gf_inv(aff_inv(data));

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// derived backwards from the round-10 key on the fly.
module aes128_inv_cipher_iter
    import aes128_inv_cipher_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct_in,
    input  logic [127:0] rk10_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [3:0]   rnd_q;
    logic         busy_q;
    logic         done_q;
    logic [127:0] pt_q;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  w0n_s, w1n_s, w2n_s, w3n_s;
    logic [31:0]  rot_s;
    logic [31:0]  subw_s;
    logic [7:0]   rcon_s;
    logic [127:0] rk_d;
    logic [127:0] sr_s;
    logic [127:0] isb_s;
    logic [127:0] ark_s;
    logic [127:0] mix_s;
    logic [127:0] state_d;
    logic         last_s;

    // InvMixColumns on one column, row 0 in the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Undo the word chaining of the key schedule; w3' feeds SubWord.
    always_comb begin
        w0_s  = rk_q[127:96];
        w1_s  = rk_q[95:64];
        w2_s  = rk_q[63:32];
        w3_s  = rk_q[31:0];
        w3n_s = w3_s ^ w2_s;
        w2n_s = w2_s ^ w1_s;
        w1n_s = w1_s ^ w0_s;
    end

    assign rot_s = {w3n_s[23:0], w3n_s[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            sbox u_sbox (
                .data (rot_s[8*gi +: 8]),
                .dout (subw_s[8*gi +: 8])
            );
        end
    endgenerate

    // Finish the previous round key with SubWord(RotWord(w3')) and rcon.
    always_comb begin
        rcon_s = rcon_lookup(rnd_q);
        w0n_s  = w0_s ^ subw_s ^ {rcon_s, 24'h000000};
        rk_d   = {w0n_s, w1n_s, w2n_s, w3n_s};
    end

    // InvShiftRows: row r rotates right by r columns, so new (r,c) takes old (r,c-r).
    genvar gc, gr;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign sr_s[127 - 8*(4*gc + gr) -: 8] =
                    state_q[127 - 8*(4*((gc + 4 - gr) % 4) + gr) -: 8];
                inv_sbox u_inv_sbox (
                    .data (sr_s[127 - 8*(4*gc + gr) -: 8]),
                    .dout (isb_s[127 - 8*(4*gc + gr) -: 8])
                );
            end
        end
    endgenerate

    // AddRoundKey, then InvMixColumns except on the final inverse round.
    always_comb begin
        last_s = (rnd_q == 4'd1);
        ark_s  = isb_s ^ rk_d;
        mix_s  = {inv_mix_col(ark_s[127:96]), inv_mix_col(ark_s[95:64]),
                  inv_mix_col(ark_s[63:32]),  inv_mix_col(ark_s[31:0])};
        if (last_s) begin
            state_d = ark_s;
        end else begin
            state_d = mix_s;
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= 128'h0;
            rk_q    <= 128'h0;
            rnd_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pt_q    <= 128'h0;
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ct_in ^ rk10_in;
                        rk_q    <= rk10_in;
                        rnd_q   <= 4'd10;
                        busy_q  <= 1'b1;
                        fsm_q   <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        fsm_q   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rk_q    <= rk_d;
                    state_q <= state_d;
                    rnd_q   <= rnd_q - 4'd1;
                    if (last_s) begin
                        pt_q   <= state_d;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= ST_DONE;
                    end else begin
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        fsm_q  <= ST_RUN;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    fsm_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign pt_out = pt_q;

endmodule
